dc_restore_iir: RTL and testbench

DC_RESTORE_IIR -- requirements
Module: dc_restore_iir

---
 rtl/dc_iir_pkg.sv | 25 ++
 rtl/dc_restore_iir_if.sv | 11 +
 rtl/serial_mult.sv | 50 +++++
 rtl/dc_restore_iir.sv | 117 +++++++++++
 tb/tb_dc_restore_iir.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dc_iir_pkg.sv
// Shared widths, FSM state type and output saturation for the DC-restore leaky integrator.
package dc_iir_pkg;

  localparam int unsigned ACC_W     = 20;
  localparam int unsigned FRAC_W    = 8;
  localparam int unsigned COEF_FRAC = 6;
  localparam int unsigned PROD_W    = 28;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

  localparam logic signed [ACC_W-1:0] SAT8_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT8_LO = ACC_W'(-128);

  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] x);
    if (x > SAT8_HI) begin
      return 8'sd127;
    end else if (x < SAT8_LO) begin
      return -8'sd128;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/dc_restore_iir_if.sv
// Sample-in / sample-out handshake bundle of the DC-restore integrator.
interface dc_restore_iir_if;
  logic signed [7:0] d_in;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] d_out;
  logic              out_valid;

  modport master (output d_in, output in_valid, input in_ready, input d_out, input out_valid);
  modport slave  (input d_in, input in_valid, output in_ready, output d_out, output out_valid);
endinterface

// File: rtl/serial_mult.sv
// Serial shift-add multiplier: signed 20-bit multiplicand times unsigned 8-bit multiplier,
// one multiplier bit per step, LSB first.
module serial_mult
  import dc_iir_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic                     step_i,
  input  logic signed [ACC_W-1:0]  a_i,
  input  logic [7:0]               b_i,
  output logic signed [PROD_W-1:0] prod_o,
  output logic                     done_o
);

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [PROD_W-1:0] a_ext;

  assign a_ext = $signed({{(PROD_W - ACC_W){a_i[ACC_W-1]}}, a_i});

  always_comb begin
    prod_d = prod_q;
    cnt_d  = cnt_q;
    if (clear_i || start_i) begin
      prod_d = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      if (b_i[cnt_q]) begin
        prod_d = prod_q + (a_ext <<< cnt_q);
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end

  assign prod_o = prod_q;
  assign done_o = step_i && (cnt_q == CNT_W'(7));

endmodule

// File: rtl/dc_restore_iir.sv
// Leaky integrator y[n] = x[n] + COEF/64 * y[n-1] with noise-shaped rounding,
// one sample per 11 cycles using a serial multiplier.
module dc_restore_iir
  import dc_iir_pkg::*;
#(
  parameter logic [7:0]  COEF      = 8'd60,
  parameter int unsigned OUT_SHIFT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  dc_restore_iir_if.slave bus
);

  localparam int unsigned SUM_W = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  state_e                   state_q, state_d;
  logic signed [7:0]        x_q, x_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [COEF_FRAC-1:0]     err_q, err_d;
  logic signed [7:0]        dout_q, dout_d, dout_next;
  logic                     mult_start, mult_step, mult_done;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  shaped, scaled, x_ext, sum;

  serial_mult u_mult (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (clear),
    .start_i (mult_start),
    .step_i  (mult_step),
    .a_i     (acc_q),
    .b_i     (COEF),
    .prod_o  (prod),
    .done_o  (mult_done)
  );

  // Remainder of the previous /64 is fed back so truncation error does not accumulate.
  assign shaped = $signed({prod[PROD_W-1], prod})
                + $signed({{(SUM_W - COEF_FRAC){1'b0}}, err_q});
  assign scaled = shaped >>> COEF_FRAC;
  assign x_ext  = $signed({{(SUM_W - 8 - FRAC_W){x_q[7]}}, x_q, {FRAC_W{1'b0}}});
  assign sum    = x_ext + scaled;

  always_comb begin
    if (sum > ACC_MAX) begin
      acc_next = ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      acc_next = ACC_MIN[ACC_W-1:0];
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
  end

  assign dout_next = sat8(acc_next >>> (FRAC_W + OUT_SHIFT));
  assign mult_step = (state_q == StMul);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    err_d      = err_q;
    dout_d     = dout_q;
    mult_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d        = bus.d_in;
          mult_start = 1'b1;
          state_d    = StMul;
        end
      end
      StMul: begin
        if (mult_done) state_d = StAcc;
      end
      StAcc: begin
        acc_d   = acc_next;
        err_d   = shaped[COEF_FRAC-1:0];
        dout_d  = dout_next;
        state_d = StOut;
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Clear wins over everything, including a sample offered in the same cycle; d_out holds.
    if (clear) begin
      state_d    = StIdle;
      acc_d      = '0;
      err_d      = '0;
      dout_d     = dout_q;
      mult_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut) && !clear;
  assign bus.d_out     = dout_q;

endmodule

// File: tb/tb_dc_restore_iir.sv
// Directed bench for dc_restore_iir: COEF=60, COEF=0 and COEF=64 instances share one stimulus.
module tb_dc_restore_iir;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic              in_valid;
  logic signed [7:0] d_in;

  int n_checks = 0;
  int n_errors = 0;
  int imp_exp [5] = '{3, 3, 3, 3, 2};

  always #5 clk = ~clk;

  dc_restore_iir_if bus60 ();
  dc_restore_iir_if bus0 ();
  dc_restore_iir_if bus64 ();

  assign bus60.d_in = d_in;
  assign bus60.in_valid = in_valid;
  assign bus0.d_in = d_in;
  assign bus0.in_valid = in_valid;
  assign bus64.d_in = d_in;
  assign bus64.in_valid = in_valid;

  dc_restore_iir #(.COEF(8'd60), .OUT_SHIFT(4)) dut60 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus60.slave));
  dc_restore_iir #(.COEF(8'd0), .OUT_SHIFT(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus0.slave));
  dc_restore_iir #(.COEF(8'd64), .OUT_SHIFT(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus64.slave));

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!bus60.in_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("in_ready_seen", bus60.in_ready, 1);
  endtask

  // Offers one sample, returns in its OUT cycle; lat counts cycles after the accepting edge.
  task automatic send(input logic signed [7:0] x, output int lat);
    wait_ready();
    d_in = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!bus60.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("out_valid_seen", bus60.out_valid, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev;
    int mono_bad;
    int acc_n;
    int last_c;
    int ov_n;
    int held;
    logic signed [7:0] last_acc;

    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b1;
    d_in     = 8'sd55;
    last_acc = '0;

    // Reset held with in_valid high
    #22;
    check_eq("rst_dout", bus60.d_out, 0);
    check_eq("rst_out_valid", bus60.out_valid, 0);
    reset_n = 1'b1;
    #1;
    check_eq("rst_in_ready", bus60.in_ready, 1);
    in_valid = 1'b0;
    tick();

    // Impulse
    send(8'sd64, lat);
    check_eq("imp_latency", lat, 10);
    check_eq("imp_first", bus60.d_out, 4);
    check_eq("coef0_first", bus0.d_out, 4);
    for (int i = 0; i < 5; i++) begin
      send(8'sd0, lat);
      check_eq("imp_decay", bus60.d_out, imp_exp[i]);
    end
    prev = bus60.d_out;
    mono_bad = 0;
    for (int i = 0; i < 35; i++) begin
      send(8'sd0, lat);
      if (bus60.d_out > prev || bus60.d_out < 0) mono_bad++;
      prev = bus60.d_out;
    end
    check_eq("imp_monotone", mono_bad, 0);
    check_eq("imp_final", bus60.d_out, 0);
    check_eq("coef0_zero", bus0.d_out, 0);

    // DC step
    do_clear();
    send(8'sd100, lat);
    check_eq("dc_s0", bus60.d_out, 6);
    send(8'sd100, lat);
    check_eq("dc_s1", bus60.d_out, 12);
    prev = bus60.d_out;
    mono_bad = 0;
    for (int i = 0; i < 198; i++) begin
      send(8'sd100, lat);
      if (bus60.d_out < prev) mono_bad++;
      prev = bus60.d_out;
    end
    check_eq("dc_monotone", mono_bad, 0);
    check_eq("dc_settle", (bus60.d_out >= 99 && bus60.d_out <= 100), 1);

    // Handshake with d_in changing every cycle
    do_clear();
    acc_n = 0;
    last_c = -1;
    for (int c = 0; c < 44; c++) begin
      d_in = 8'(c * 37 + 11);
      in_valid = 1'b1;
      if (bus60.in_ready) begin
        if (last_c >= 0) check_eq("hs_spacing", c - last_c, 11);
        last_c = c;
        last_acc = d_in;
        acc_n++;
      end
      if (bus0.out_valid) check_eq("hs_value", bus0.d_out, last_acc >>> 4);
      tick();
    end
    in_valid = 1'b0;
    check_eq("hs_accepts", acc_n, 4);

    // Clear in the middle of MUL
    wait_ready();
    held = bus60.d_out;
    d_in = 8'sd50;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_in_ready", bus60.in_ready, 1);
    check_eq("clr_acc", dut60.acc_q, 0);
    ov_n = 0;
    repeat (15) begin
      ov_n += int'(bus60.out_valid);
      tick();
    end
    check_eq("clr_no_out", ov_n, 0);
    check_eq("clr_hold", bus60.d_out, held);

    // Reset in the middle of MUL
    wait_ready();
    d_in = 8'sd90;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #2;
    check_eq("mrst_dout", bus60.d_out, 0);
    reset_n = 1'b1;
    ov_n = 0;
    repeat (15) begin
      ov_n += int'(bus60.out_valid);
      tick();
    end
    check_eq("mrst_no_out", ov_n, 0);

    // Saturation at COEF=64
    do_clear();
    send(8'sd127, lat);
    check_eq("sat_s0", bus64.d_out, 7);
    for (int i = 0; i < 24; i++) send(8'sd127, lat);
    check_eq("sat_acc_hi", dut64.acc_q, 524287);
    check_eq("sat_dout_hi", bus64.d_out, 127);
    send(-8'sd128, lat);
    check_eq("sat_neg_s0", bus64.d_out, 119);
    prev = bus64.d_out;
    mono_bad = 0;
    for (int i = 0; i < 39; i++) begin
      send(-8'sd128, lat);
      if (bus64.d_out > prev) mono_bad++;
      prev = bus64.d_out;
    end
    check_eq("sat_no_wrap", mono_bad, 0);
    check_eq("sat_dout_lo", bus64.d_out, -128);
    check_eq("sat_acc_lo", dut64.acc_q, -524288);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
